// File: rtl/gmii_rx_frame_adapt_if.sv
// GMII receive inputs and the framed byte-stream/statistics outputs of gmii_rx_frame_adapt.
// master = PHY/consumer side, slave = the adapter.
interface gmii_rx_frame_adapt_if #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 32
);
    logic             gmii_rx_en;
    logic             gmii_rx_er;
    logic [7:0]       gmii_rxd;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sof;
    logic             out_eof;
    logic             out_err;
    logic [LEN_W-1:0] frame_len;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output gmii_rx_en, gmii_rx_er, gmii_rxd,
        input  out_valid, out_data, out_sof, out_eof, out_err,
        input  frame_len, frame_cnt, err_cnt
    );

    modport slave (
        input  gmii_rx_en, gmii_rx_er, gmii_rxd,
        output out_valid, out_data, out_sof, out_eof, out_err,
        output frame_len, frame_cnt, err_cnt
    );
endinterface

// File: rtl/gmii_rx_frame_adapt.sv
// GMII receive adapter: strips preamble/SFD, packs nibbles (10/100) or passes bytes (1000),
// and emits a framed byte stream with sof/eof/err, frame length and saturating statistics.
module gmii_rx_frame_adapt #(
    parameter int unsigned MAX_PRE = 15,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                  gmii_rxc,
    input  logic                  rst_n,
    input  logic [1:0]            speed_mode,
    gmii_rx_frame_adapt_if.slave  bus
);
    localparam int unsigned PRE_W = $clog2(2 * MAX_PRE + 2);
    localparam logic [PRE_W-1:0] PRE_LIM_B = PRE_W'(MAX_PRE);
    localparam logic [PRE_W-1:0] PRE_LIM_N = PRE_W'(2 * MAX_PRE);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t             r_state;
    logic               r_nib_mode;
    logic [PRE_W-1:0]   r_pre_cnt;
    logic               r_phase;
    logic [3:0]         r_lo_nib;
    logic [7:0]         r_hold;
    logic               r_hold_full;
    logic               r_first;
    logic               r_rx_er_seen;
    logic [LEN_W-1:0]   r_len;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_out_sof;
    logic               r_out_eof;
    logic               r_out_err;
    logic [LEN_W-1:0]   r_frame_len;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    // Preamble evaluation: in IDLE the current symbol is judged with the live mode and a zero count
    logic               w_nib_now;
    logic               w_in_idle;
    logic               w_pre_nib;
    logic [PRE_W-1:0]   w_pre_cnt;
    logic [PRE_W-1:0]   w_pre_cnt_nx;
    logic [PRE_W-1:0]   w_pre_lim;
    logic               w_sym_pre;
    logic               w_sym_sfd;

    assign w_nib_now    = (speed_mode == 2'b00) || (speed_mode == 2'b01);
    assign w_in_idle    = (r_state == S_IDLE);
    assign w_pre_nib    = w_in_idle ? w_nib_now : r_nib_mode;
    assign w_pre_cnt    = w_in_idle ? '0 : r_pre_cnt;
    assign w_pre_cnt_nx = w_pre_cnt + PRE_W'(1);
    assign w_pre_lim    = w_pre_nib ? PRE_LIM_N : PRE_LIM_B;
    assign w_sym_pre    = w_pre_nib ? (bus.gmii_rxd[3:0] == 4'h5) : (bus.gmii_rxd == 8'h55);
    assign w_sym_sfd    = w_pre_nib ? (bus.gmii_rxd[3:0] == 4'hD) : (bus.gmii_rxd == 8'hD5);

    logic               w_byte_done;
    logic [7:0]         w_byte;
    logic [LEN_W-1:0]   w_len_inc;
    logic               w_er_seen;
    logic               w_eof_err;
    logic [CNT_W-1:0]   w_frame_cnt_inc;
    logic [CNT_W-1:0]   w_err_cnt_inc;

    assign w_byte_done     = r_nib_mode ? r_phase : 1'b1;
    assign w_byte          = r_nib_mode ? {bus.gmii_rxd[3:0], r_lo_nib} : bus.gmii_rxd;
    assign w_len_inc       = (&r_len) ? r_len : r_len + LEN_W'(1);
    assign w_er_seen       = r_rx_er_seen | bus.gmii_rx_er;
    assign w_eof_err       = w_er_seen | r_phase | (w_len_inc < LEN_W'(MIN_LEN))
                           | (w_len_inc > LEN_W'(MAX_LEN));
    assign w_frame_cnt_inc = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);
    assign w_err_cnt_inc   = (&r_err_cnt) ? r_err_cnt : r_err_cnt + CNT_W'(1);

    always_ff @(posedge gmii_rxc) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_nib_mode   <= 1'b0;
            r_pre_cnt    <= '0;
            r_phase      <= 1'b0;
            r_lo_nib     <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_first      <= 1'b0;
            r_rx_er_seen <= 1'b0;
            r_len        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_out_err    <= 1'b0;
            r_frame_len  <= '0;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_err   <= 1'b0;
            case (r_state)
                S_IDLE, S_PRE: begin
                    if (!bus.gmii_rx_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_in_idle) r_nib_mode <= w_nib_now;
                        if (w_sym_pre && (w_pre_cnt_nx <= w_pre_lim)) begin
                            r_pre_cnt <= w_pre_cnt_nx;
                            r_state   <= S_PRE;
                        end else if (w_sym_sfd && (w_pre_cnt != '0)) begin
                            r_state      <= S_DATA;
                            r_phase      <= 1'b0;
                            r_hold_full  <= 1'b0;
                            r_first      <= 1'b1;
                            r_len        <= '0;
                            r_rx_er_seen <= 1'b0;
                        end else begin
                            r_state   <= S_DROP;
                            r_err_cnt <= w_err_cnt_inc;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.gmii_rx_en) begin
                        r_rx_er_seen <= w_er_seen;
                        if (r_nib_mode) begin
                            r_phase <= ~r_phase;
                            if (!r_phase) r_lo_nib <= bus.gmii_rxd[3:0];
                        end
                        // Hold one byte back so the final byte can carry eof
                        if (w_byte_done) begin
                            r_hold      <= w_byte;
                            r_hold_full <= 1'b1;
                            if (r_hold_full) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_hold;
                                r_out_sof   <= r_first;
                                r_first     <= 1'b0;
                                r_len       <= w_len_inc;
                            end
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_hold_full <= 1'b0;
                        r_phase     <= 1'b0;
                        r_pre_cnt   <= '0;
                        if (r_hold_full) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_hold;
                            r_out_sof   <= r_first;
                            r_out_eof   <= 1'b1;
                            r_out_err   <= w_eof_err;
                            r_len       <= w_len_inc;
                            r_frame_len <= w_len_inc;
                            if (w_eof_err) r_err_cnt <= w_err_cnt_inc;
                            else           r_frame_cnt <= w_frame_cnt_inc;
                        end else begin
                            r_err_cnt <= w_err_cnt_inc;
                        end
                    end
                end
                S_DROP: begin
                    if (!bus.gmii_rx_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_eof   = r_out_eof;
    assign bus.out_err   = r_out_err;
    assign bus.frame_len = r_frame_len;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_gmii_rx_frame_adapt.sv
// Directed, table-driven bench for gmii_rx_frame_adapt plus a narrow-counter saturation instance.
module tb_gmii_rx_frame_adapt;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CNT_WB = 3;

    logic       clk = 1'b0;
    always #4 clk = ~clk;

    logic       rst_n_a;
    logic       rst_n_b;
    logic [1:0] spd_a;
    logic [1:0] spd_b;

    gmii_rx_frame_adapt_if #(.LEN_W(LEN_W), .CNT_W(CNT_W))  ifa ();
    gmii_rx_frame_adapt_if #(.LEN_W(LEN_W), .CNT_W(CNT_WB)) ifb ();

    gmii_rx_frame_adapt #(
        .MAX_PRE(15), .MIN_LEN(64), .MAX_LEN(1522), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut_a (
        .gmii_rxc(clk), .rst_n(rst_n_a), .speed_mode(spd_a), .bus(ifa)
    );

    gmii_rx_frame_adapt #(
        .MAX_PRE(15), .MIN_LEN(64), .MAX_LEN(1522), .LEN_W(LEN_W), .CNT_W(CNT_WB)
    ) dut_b (
        .gmii_rxc(clk), .rst_n(rst_n_b), .speed_mode(spd_b), .bus(ifb)
    );

    typedef struct {
        bit          rst_n;
        bit          en;
        bit          er;
        logic [7:0]  d;
        logic [1:0]  spd;
        bit          ev;
        logic [7:0]  ed;
        bit          esof;
        bit          eeof;
        bit          eerr;
        logic [15:0] elen;
        logic [31:0] efc;
        logic [31:0] eec;
        bit          chk_all;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_fc;
    logic [31:0] exp_ec;
    int          checks;
    int          errors;
    int          cur_idx;

    function automatic void push(input bit rst, input bit en, input bit er, input logic [7:0] d,
                                 input logic [1:0] spd, input bit ev, input logic [7:0] ed,
                                 input bit sof, input bit eof, input bit err,
                                 input logic [15:0] len, input bit all);
        vec_t v;
        v.rst_n = rst; v.en = en; v.er = er; v.d = d; v.spd = spd;
        v.ev = ev; v.ed = ed; v.esof = sof; v.eeof = eof; v.eerr = err; v.elen = len;
        v.efc = exp_fc; v.eec = exp_ec; v.chk_all = all;
        vq.push_back(v);
    endfunction

    function automatic void push_in(input bit en, input logic [7:0] d, input logic [1:0] spd);
        push(1'b1, en, 1'b0, d, spd, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endfunction

    // Byte-mode frame: npre x 0x55, 0xD5, n bytes 0..n-1, one idle gap cycle
    function automatic void add_byte_frame(input int npre, input int n, input int er_at,
                                           input logic [1:0] spd);
        bit dropped;
        bit bad;
        dropped = 1'b0;
        for (int p = 0; p < npre; p++) begin
            if (!dropped && p == 15) begin exp_ec++; dropped = 1'b1; end
            push_in(1'b1, 8'h55, spd);
        end
        if (!dropped && npre == 0) begin exp_ec++; dropped = 1'b1; end
        push_in(1'b1, 8'hD5, spd);
        for (int i = 0; i < n; i++)
            push(1'b1, 1'b1, (i == er_at), 8'(i), spd, (!dropped && i > 0), 8'(i - 1),
                 (!dropped && i == 1), 1'b0, 1'b0, 16'h0, 1'b0);
        if (dropped) begin
            push_in(1'b0, 8'h00, spd);
        end else if (n == 0) begin
            exp_ec++;
            push_in(1'b0, 8'h00, spd);
        end else begin
            bad = (er_at >= 0) || (n < 64) || (n > 1522);
            if (bad) exp_ec++; else exp_fc++;
            push(1'b1, 1'b0, 1'b0, 8'h00, spd, 1'b1, 8'(n - 1), (n == 1), 1'b1, bad,
                 16'(n), 1'b0);
        end
    endfunction

    // Nibble-mode frame: low nibble first; speed input shows 2'b10 for data nibbles in [tlo,thi)
    function automatic void add_nib_frame(input int npre, input int nnib, input logic [1:0] spd,
                                          input int tlo, input int thi);
        logic [7:0] bv;
        logic [3:0] nib;
        logic [1:0] s;
        int         nb;
        bit         bad;
        for (int p = 0; p < npre; p++) push_in(1'b1, 8'h05, spd);
        push_in(1'b1, 8'h0D, spd);
        for (int j = 0; j < nnib; j++) begin
            bv  = 8'(j / 2);
            nib = (j % 2 == 1) ? bv[7:4] : bv[3:0];
            s   = (j >= tlo && j < thi) ? 2'b10 : spd;
            push(1'b1, 1'b1, 1'b0, {4'h0, nib}, s, (j % 2 == 1 && j >= 3), 8'((j - 3) / 2),
                 (j == 3), 1'b0, 1'b0, 16'h0, 1'b0);
        end
        nb = nnib / 2;
        if (nb == 0) begin
            exp_ec++;
            push_in(1'b0, 8'h00, spd);
        end else begin
            bad = (nnib % 2 == 1) || (nb < 64);
            if (bad) exp_ec++; else exp_fc++;
            push(1'b1, 1'b0, 1'b0, 8'h00, spd, 1'b1, 8'(nb - 1), (nb == 1), 1'b1, bad,
                 16'(nb), 1'b0);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, cur_idx, act, exp);
        end
    endtask

    task automatic b_step(input bit en, input logic [7:0] d);
        ifb.gmii_rx_en = en;
        ifb.gmii_rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic b_frame(input int n);
        for (int p = 0; p < 7; p++) b_step(1'b1, 8'h55);
        b_step(1'b1, 8'hD5);
        for (int i = 0; i < n; i++) b_step(1'b1, (n == 1) ? 8'hA5 : 8'(i));
        b_step(1'b0, 8'h00);
    endtask

    initial begin
        checks = 0; errors = 0; cur_idx = 0;
        exp_fc = '0; exp_ec = '0;
        rst_n_a = 1'b0; spd_a = 2'b10;
        ifa.gmii_rx_en = 1'b0; ifa.gmii_rx_er = 1'b0; ifa.gmii_rxd = 8'h00;
        rst_n_b = 1'b0; spd_b = 2'b10;
        ifb.gmii_rx_en = 1'b0; ifb.gmii_rx_er = 1'b0; ifb.gmii_rxd = 8'h00;

        // Vector table
        push(1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        push_in(1'b0, 8'h00, 2'b10);
        add_byte_frame(7, 64, -1, 2'b10);
        add_nib_frame(15, 128, 2'b01, 20, 60);
        add_byte_frame(7, 64, 10, 2'b10);
        add_byte_frame(7, 40, -1, 2'b10);
        push_in(1'b1, 8'h55, 2'b10);
        exp_ec++;
        push_in(1'b1, 8'h57, 2'b10);
        for (int i = 0; i < 64; i++) push_in(1'b1, 8'(i), 2'b10);
        push_in(1'b0, 8'h00, 2'b10);
        add_nib_frame(15, 129, 2'b01, -1, -1);
        add_byte_frame(7, 0, -1, 2'b10);
        add_byte_frame(15, 64, -1, 2'b10);
        add_byte_frame(16, 64, -1, 2'b10);
        add_byte_frame(0, 64, -1, 2'b10);
        add_byte_frame(7, 1, -1, 2'b10);
        add_byte_frame(7, 1522, -1, 2'b10);
        add_byte_frame(7, 1523, -1, 2'b10);
        add_nib_frame(7, 128, 2'b00, -1, -1);
        add_byte_frame(7, 64, -1, 2'b11);
        // Reset mid-frame at byte 30, then a clean frame
        for (int p = 0; p < 7; p++) push_in(1'b1, 8'h55, 2'b10);
        push_in(1'b1, 8'hD5, 2'b10);
        for (int i = 0; i < 30; i++)
            push(1'b1, 1'b1, 1'b0, 8'(i), 2'b10, (i > 0), 8'(i - 1), (i == 1), 1'b0, 1'b0,
                 16'h0, 1'b0);
        exp_fc = '0; exp_ec = '0;
        push(1'b0, 1'b0, 1'b0, 8'h1E, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        push_in(1'b0, 8'h00, 2'b10);
        add_byte_frame(7, 64, -1, 2'b10);

        foreach (vq[k]) begin
            cur_idx = k;
            rst_n_a = vq[k].rst_n;
            spd_a   = vq[k].spd;
            ifa.gmii_rx_en = vq[k].en;
            ifa.gmii_rx_er = vq[k].er;
            ifa.gmii_rxd   = vq[k].d;
            @(posedge clk);
            #1;
            check("out_valid", 32'(ifa.out_valid), 32'(vq[k].ev));
            if (vq[k].ev || vq[k].chk_all) begin
                check("out_data", 32'(ifa.out_data), 32'(vq[k].ed));
                check("out_sof", 32'(ifa.out_sof), 32'(vq[k].esof));
                check("out_eof", 32'(ifa.out_eof), 32'(vq[k].eeof));
            end
            if ((vq[k].ev && vq[k].eeof) || vq[k].chk_all) begin
                check("out_err", 32'(ifa.out_err), 32'(vq[k].eerr));
                check("frame_len", 32'(ifa.frame_len), 32'(vq[k].elen));
            end
            check("frame_cnt", ifa.frame_cnt, vq[k].efc);
            check("err_cnt", ifa.err_cnt, vq[k].eec);
        end

        // Narrow counters: saturation and a single-byte frame
        cur_idx = -1;
        rst_n_a = 1'b0;
        ifa.gmii_rx_en = 1'b0;
        b_step(1'b0, 8'h00);
        rst_n_b = 1'b1;
        b_step(1'b0, 8'h00);
        check("b_reset_fcnt", 32'(ifb.frame_cnt), 32'd0);
        for (int f = 1; f <= 9; f++) begin
            b_frame(64);
            check("b_eof", 32'(ifb.out_eof), 32'd1);
            check("b_err", 32'(ifb.out_err), 32'd0);
            check("b_frame_cnt", 32'(ifb.frame_cnt), (f < 7) ? 32'(f) : 32'd7);
        end
        b_frame(1);
        check("b1_valid", 32'(ifb.out_valid), 32'd1);
        check("b1_data", 32'(ifb.out_data), 32'hA5);
        check("b1_sof", 32'(ifb.out_sof), 32'd1);
        check("b1_eof", 32'(ifb.out_eof), 32'd1);
        check("b1_err", 32'(ifb.out_err), 32'd1);
        check("b1_len", 32'(ifb.frame_len), 32'd1);
        check("b1_err_cnt", 32'(ifb.err_cnt), 32'd1);
        check("b1_frame_cnt", 32'(ifb.frame_cnt), 32'd7);
        b_step(1'b0, 8'h00);
        check("b_pulse_clear", 32'(ifb.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
